bmux_rr: RTL
============

Name: bmux_rr

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer; successor to the fixed 8x16 combinational datapath mux.
- Two modes: direct select (index from control) and round-robin arbitration among requesting channels.
- One-cycle registered output with valid, source index and per-channel ack pulse.
- Used where several datapath/memory clients share one bus port.

Parameters:
- WIDTH, 16, data width per channel.
- N, 8, channel count (2..16; need not be a power of 2).
- SEL_W, clog2(N), width of select/source index; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = direct select, 1 = round-robin.
- s  in  SEL_W  channel index in direct mode.
- req  in  N  per-channel request, used in both modes.
- d  in  N*WIDTH  flattened channel data; channel i is d[i*WIDTH +: WIDTH].
- hold  in  1  stall; freezes output and arbitration state.
- r  out  WIDTH  registered selected data.
- r_valid  out  1  r holds a newly selected value.
- r_src  out  SEL_W  index of the channel in r.
- ack  out  N  one-hot, single-cycle pulse to the accepted channel.

Behaviour:
- Reset (rst_n=0, asynchronous): r=0, r_valid=0, r_src=0, ack=0, round-robin pointer ptr=0. Reset takes effect immediately, with no clock edge. The first update after release is on the first rising edge with rst_n=1.
- Latency: inputs sampled at edge k appear on r/r_valid/r_src/ack after edge k. No combinational input-to-output path.
- hold=1 at an edge:
  - r, r_valid, r_src and ptr keep their values.
  - ack is driven 0, so no accept occurs.
  - hold overrides mode, s and req.
- Direct mode (mode=0, hold=0):
  - s < N: r<=d[s], r_src<=s, r_valid<=1, ack<=onehot(s) if req[s], else 0.
  - s >= N (only possible when N is not a power of 2): r<=0, r_src<=0, r_valid<=0, ack<=0.
  - ptr is unchanged in direct mode.
- Round-robin mode (mode=1, hold=0):
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Winner found: r<=d[win], r_src<=win, r_valid<=1, ack<=onehot(win), ptr<=(win+1) mod N. When win=N-1, ptr wraps to 0.
  - No request: r and r_src hold, r_valid<=0, ack<=0, ptr unchanged.
  - A single requester is granted every cycle.
- Mode change takes effect at the next edge. ptr is not cleared on a mode change.
- ack is never multi-hot. ack is asserted only together with r_valid=1.
- req, s and d are assumed synchronous to clk. There is no internal synchronisation.

Decomposition:
- Shared package bmux_pkg:
  - MODE_DIRECT=1'b0, MODE_RR=1'b1.
  - clog2 function used to derive SEL_W.
- One sub-module, rr_pick (combinational):
  - Inputs: req[N-1:0], ptr[SEL_W-1:0].
  - Outputs: win[SEL_W-1:0], any.
  - Implementation: rotate, priority-encode, rotate back.
- Top level holds the output registers, ptr, the mode mux and the hold logic.

Test Plan:
1. N=8, WIDTH=16, d[i]=i+1, mode=0, req=8'hFF, sweep s=0..7 one per cycle -> one edge later r=s+1, r_src=s, r_valid=1, ack=onehot(s).
2. mode=1, req=8'hFF from reset -> r_src sequence 0,1,...,7,0 on consecutive edges; r=1..8,1; ack one-hot each cycle.
3. mode=1, req=8'b1000_0100 -> grants 2,7,2,7; after the grant of 7, ptr wraps to 0 and the next grant is 2.
4. mode=1, req=8'hFF; assert hold for 2 cycles after the grant of 3 -> r=4, r_src=3 held, ack=0; first grant after release is 4.
5. Pull rst_n low asynchronously mid-stream (mode=1, r_valid=1) -> r=0, r_valid=0, ack=0 before the next clock edge; after release the first grant is channel 0.
6. N=5: mode=0, s=6 -> r=0, r_valid=0, ack=0. mode=1, req=0 -> r_valid=0, r unchanged from the previous value.

Source files
------------

// File: rtl/bmux_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// bmux_pkg : shared mode encodings and width helper for bmux_rr. Rev 1.0
// ------------------------------------------------------------------------
package bmux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Ceiling log2, never below 1 so a select port always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmux_rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------------
// rr_pick : round-robin winner search starting at ptr (rotate, encode, unrotate). Rev 1.0
// ------------------------------------------------------------------------
module rr_pick
  import bmux_pkg::*;
#(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  // Modulo-N add; both operands are below N so one conditional subtract suffices.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a,
                                                input logic [SEL_W:0]   b);
    logic [SEL_W:0] t;
    t = {1'b0, a} + b;
    if (t >= (SEL_W+1)'(N)) t = t - (SEL_W+1)'(N);
    return t[SEL_W-1:0];
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[wrap_add(ptr, (SEL_W+1)'(i))];
    end
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    any = |rot;
    win = wrap_add(ptr, {1'b0, off});
  end

endmodule
`default_nettype wire

// File: rtl/bmux_rr.sv
`default_nettype none
// ------------------------------------------------------------------------
// bmux_rr : N-channel registered mux, direct select or round-robin arbitration. Rev 1.0
// ------------------------------------------------------------------------
module bmux_rr
  import bmux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 8,
  localparam int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   s,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] d,
  input  logic               hold,
  output logic [WIDTH-1:0]   r,
  output logic               r_valid,
  output logic [SEL_W-1:0]   r_src,
  output logic [N-1:0]       ack
);

  logic [WIDTH-1:0] ch [N];
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             s_ok;

  logic [WIDTH-1:0] r_nx;
  logic             valid_nx;
  logic [SEL_W-1:0] src_nx;
  logic [N-1:0]     ack_nx;
  logic [SEL_W-1:0] ptr_nx;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign ch[i] = d[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // Only reachable as false when N is not a power of two.
  assign s_ok = ({1'b0, s} < (SEL_W+1)'(N));

  always_comb begin
    r_nx     = r;
    valid_nx = r_valid;
    src_nx   = r_src;
    ack_nx   = '0;
    ptr_nx   = ptr;
    if (!hold) begin
      if (mode == MODE_DIRECT) begin
        if (s_ok) begin
          r_nx      = ch[s];
          src_nx    = s;
          valid_nx  = 1'b1;
          ack_nx[s] = req[s];
        end else begin
          r_nx     = '0;
          src_nx   = '0;
          valid_nx = 1'b0;
        end
      end else if (any) begin
        r_nx        = ch[win];
        src_nx      = win;
        valid_nx    = 1'b1;
        ack_nx[win] = 1'b1;
        ptr_nx      = (win == SEL_W'(N - 1)) ? '0 : win + 1'b1;
      end else begin
        valid_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r       <= '0;
      r_valid <= 1'b0;
      r_src   <= '0;
      ack     <= '0;
      ptr     <= '0;
    end else begin
      r       <= r_nx;
      r_valid <= valid_nx;
      r_src   <= src_nx;
      ack     <= ack_nx;
      ptr     <= ptr_nx;
    end
  end

endmodule
`default_nettype wire
